conv_node_ctrl: RTL and testbench
=================================

Name: conv_node_ctrl

Overview:
- Sequencer for a bank of conv_node instances that share one control bus.
- Accepts one input window per valid/ready handshake.
- Drives start, input_index and add_bias through one full MAC-plus-bias pass.
- Presents the finished node outputs downstream with a valid/ready handshake and flags the last window of a frame.

Parameters:
- KERNEL_HEIGHT, 3, rows per convolution window.
- KERNEL_WIDTH, 2, columns per convolution window.
- NUM_WINDOWS, 4, windows per frame; sets when last_o asserts. Must be at least 1.
- Derived localparam K = KERNEL_HEIGHT*KERNEL_WIDTH.
- Derived localparam IDX_W = $clog2(K+1).
- Derived localparam WIN_W = $clog2(NUM_WINDOWS), minimum 1.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  upstream window register holds a new window.
- ready_o  out  1  controller can accept a window.
- load_o  out  1  capture strobe for the window register feeding node data_i; equals valid_i & ready_o.
- start_o  out  1  to node start_i; clears node accumulators and overflow flags.
- input_index_o  out  IDX_W  to node input_index; also the weight-memory read address.
- add_bias_o  out  1  to node add_bias; weight memory presents the bias word at address K.
- valid_o  out  1  node data_o holds a finished, ReLU'd result.
- ready_i  in  1  downstream accepts the result.
- last_o  out  1  result belongs to window NUM_WINDOWS-1; qualified by valid_o.
- busy_o  out  1  state is not IDLE.

Behaviour:
- States: IDLE, START, MAC, BIAS, OUT. State register, idx counter (IDX_W bits) and window counter (WIN_W bits) use asynchronous reset.
- Reset: state IDLE, idx 0, window count 0. start_o, add_bias_o, valid_o, last_o, busy_o and input_index_o all 0. ready_o is 1 as soon as reset deasserts.
- Reset asserted mid-pass aborts immediately. No result is emitted and the window counter returns to 0.
- ready_o = (state==IDLE) | (state==OUT & ready_i). It is combinational; load_o is combinational from it.
- IDLE: on valid_i, go to START.
- START (1 cycle): start_o=1, input_index_o=0, idx cleared. Next state MAC.
- MAC (K cycles): input_index_o=idx, counting 0..K-1, add_bias_o=0. When idx==K-1, go to BIAS.
- BIAS (1 cycle): add_bias_o=1, input_index_o=K. The node registers its saturated/ReLU output at the end of this cycle. Next state OUT.
- OUT: valid_o=1, last_o=(win==NUM_WINDOWS-1), input_index_o=0. valid_o holds until ready_i.
  - On ready_i: window counter increments, wrapping to 0 after NUM_WINDOWS-1.
  - If valid_i is also high (back-to-back), go straight to START; otherwise go to IDLE.
- Latency: handshake at edge e0 gives start_o in cycle 1, MAC in cycles 2..K+1, BIAS in cycle K+2, valid_o from cycle K+3.
- Throughput: one window per K+3 cycles when ready_i is held high.
- In OUT, valid_o stays high and every output other than ready_o/load_o stays stable while ready_i=0. valid_i is ignored until the result handshake completes.
- All outputs except ready_o and load_o decode from registered state only. There are no combinational paths from valid_i or ready_i to start_o, add_bias_o, input_index_o or valid_o.
- NUM_WINDOWS=1: last_o asserts with every result.

Decomposition:
- Package conv_pkg holds:
  - the state enum typedef (ctrl_state_e);
  - the kernel-size helper function returning H*W;
  - the index-width constant function.
- One sub-module, wrap_counter #(MAX): synchronous increment enable, asynchronous reset, wrap at MAX-1, terminal-count output. It is instantiated for the window counter.
- The MAC idx counter stays inline.

Test Plan:
- Reset mid-MAC: reset_i pulsed during cycle 4 after accept -> all outputs 0, busy_o=0, ready_o=1 after release. A new window then produces the full sequence with last_o tracking window 0.
- Single window, K=6, ready_i=1: valid_i high one cycle -> start_o high in cycle 1; input_index_o 0,1,2,3,4,5 in cycles 2-7; add_bias_o=1 with input_index_o=6 in cycle 8; valid_o=1 in cycle 9; then IDLE.
- Backpressure: ready_i=0 for 5 cycles in OUT -> valid_o stays 1, ready_o=0, load_o=0 despite valid_i=1. Releasing ready_i gives load_o=1 in the same cycle and start_o the next cycle.
- Back-to-back: valid_i and ready_i held high for 8 windows -> one result every 9 cycles with no IDLE cycles. last_o high on results 4 and 8 only (NUM_WINDOWS=4, wrap verified).
- Node integration: 3x2 window of all 1s, weights all 2, bias 3 -> node data_o=15 when valid_o rises. With bias -20 -> data_o=0 (ReLU).
- Overflow clear: a window that saturates the node to 0x7FFF, followed by a small window (sum 5) -> second result is 5, confirming start_o cleared the node's overflow flag.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the conv_node bank controller.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_MAC,
      ST_BIAS,
      ST_OUT
   } ctrl_state_e;

   function automatic int kernel_size(input int h, input int w);
      return h * w;
   endfunction

   // One extra code point is needed so the bias address K fits alongside 0..K-1.
   function automatic int idx_width(input int k);
      return $clog2(k + 1);
   endfunction

endpackage

// File: rtl/conv_node_ctrl_wrap_counter.sv
// Modulo-MAX up counter with enable; tc_o flags the final count before wrap.
module wrap_counter #(
   parameter int MAX = 4,
   parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == W'(MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_node_ctrl.sv
// Sequencer driving a shared conv_node control bus through START, K MAC
// steps and a bias step, then holding the result under a valid/ready handshake.
module conv_node_ctrl
   import conv_pkg::*;
#(
   parameter  int KERNEL_HEIGHT = 3,
   parameter  int KERNEL_WIDTH  = 2,
   parameter  int NUM_WINDOWS   = 4,
   localparam int K             = kernel_size(KERNEL_HEIGHT, KERNEL_WIDTH),
   localparam int IDX_W         = idx_width(K),
   localparam int WIN_W         = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             load_o,
   output logic             start_o,
   output logic [IDX_W-1:0] input_index_o,
   output logic             add_bias_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o,
   output logic             busy_o
);

   ctrl_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             win_tc;
   logic             res_hs;

   // Only the accept path is combinational; everything else decodes state_q.
   assign ready_o = (state_q == ST_IDLE) | ((state_q == ST_OUT) & ready_i);
   assign load_o  = valid_i & ready_o;
   assign res_hs  = (state_q == ST_OUT) & ready_i;

   wrap_counter #(
      .MAX (NUM_WINDOWS),
      .W   (WIN_W)
   ) u_win_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (res_hs),
      .tc_o    (win_tc)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      start_o       = 1'b0;
      add_bias_o    = 1'b0;
      valid_o       = 1'b0;
      last_o        = 1'b0;
      input_index_o = '0;
      busy_o        = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            if (valid_i) state_d = ST_START;
         end
         ST_START: begin
            start_o = 1'b1;
            idx_d   = '0;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            input_index_o = idx_q;
            if (idx_q == IDX_W'(K - 1)) begin
               state_d = ST_BIAS;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_BIAS: begin
            add_bias_o    = 1'b1;
            input_index_o = IDX_W'(K);
            state_d       = ST_OUT;
         end
         ST_OUT: begin
            valid_o = 1'b1;
            last_o  = win_tc;
            if (ready_i) state_d = valid_i ? ST_START : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_conv_node_ctrl.sv
// Scoreboarded bench for conv_node_ctrl with a behavioural conv_node on the control bus.
module tb_conv_node_ctrl;

   localparam int K  = 6;
   localparam int NW = 4;

   logic       clk = 1'b0;
   logic       reset_i, valid_i, ready_i;
   logic       ready_o, load_o, start_o, add_bias_o, valid_o, last_o, busy_o;
   logic [2:0] input_index_o;

   conv_node_ctrl dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .load_o        (load_o),
      .start_o       (start_o),
      .input_index_o (input_index_o),
      .add_bias_o    (add_bias_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .last_o        (last_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural node: 16-bit saturating accumulator with sticky overflow, ReLU at bias.
   int d_in[K], d_reg[K], w[K];
   int bias, acc, node_q, t_acc;
   bit ovf;

   function automatic int node_out(input int a, input bit o, input int b);
      int s;
      s = a + b;
      if (o || s > 32767) return 32767;
      if (s < 0) return 0;
      return s;
   endfunction

   always @(posedge clk) begin
      if (load_o) d_reg <= d_in;
      if (start_o) begin
         acc <= 0;
         ovf <= 1'b0;
      end else if (add_bias_o) begin
         node_q <= node_out(acc, ovf, bias);
      end else if (input_index_o < 3'(K)) begin
         t_acc = acc + d_reg[input_index_o] * w[input_index_o];
         if (t_acc > 32767) begin
            t_acc = 32767;
            ovf  <= 1'b1;
         end else if (t_acc < -32768) begin
            t_acc = -32768;
            ovf  <= 1'b1;
         end
         acc <= t_acc;
      end
   end

   typedef struct {
      bit last;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   cur_exp = 0;
   int   exp_win = 0;

   // Expectation is pushed the moment a window is accepted.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_i && load_o) begin
         e.last = (exp_win == NW - 1);
         e.data = cur_exp;
         exp_q.push_back(e);
         exp_win = (exp_win + 1) % NW;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset_i && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_unexpected: got a result, required none queued");
         end else begin
            e = exp_q.pop_front();
            chk("result_last", last_o, e.last);
            chk("result_data", node_q, e.data);
         end
      end
   end

   // Control-bus sequence for one pass, started by an observed accept.
   task automatic run_pass(output bit nxt);
      int n;
      nxt = 1'b0;
      @(negedge clk);
      if (reset_i) return;
      chk("seq_start", start_o, 1);
      chk("seq_start_idx", input_index_o, 0);
      chk("seq_start_busy", busy_o, 1);
      chk("seq_start_valid", valid_o, 0);
      for (int k = 0; k < K; k++) begin
         @(negedge clk);
         if (reset_i) return;
         chk("seq_mac_idx", input_index_o, k);
         chk("seq_mac_ctl", {start_o, add_bias_o, valid_o}, 0);
      end
      @(negedge clk);
      if (reset_i) return;
      chk("seq_bias", add_bias_o, 1);
      chk("seq_bias_idx", input_index_o, K);
      chk("seq_bias_valid", valid_o, 0);
      @(negedge clk);
      if (reset_i) return;
      chk("seq_out_valid", valid_o, 1);
      chk("seq_out_ctl", {start_o, add_bias_o, input_index_o}, 0);
      n = 0;
      while (!ready_i && n < 50) begin
         @(negedge clk);
         if (reset_i) return;
         chk("seq_hold_valid", valid_o, 1);
         n++;
      end
      if (load_o) begin
         nxt = 1'b1;
         return;
      end
      @(negedge clk);
      if (reset_i) return;
      chk("seq_idle_busy", busy_o, 0);
      nxt = load_o;
   endtask

   initial begin : seq_chk
      bit pend;
      pend = 1'b0;
      forever begin
         if (!pend) begin
            @(negedge clk);
            pend = load_o && !reset_i;
         end else begin
            run_pass(pend);
         end
      end
   end

   task automatic send(input int exp_d);
      cur_exp = exp_d;
      @(posedge clk); #1;
      valid_i = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (load_o) break;
      end
      chk("accept", load_o, 1);
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_result();
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (valid_o && ready_i) break;
      end
      chk("result_seen", valid_o && ready_i, 1);
      @(posedge clk); #1;
   endtask

   task automatic chk_quiet(input string nm);
      chk(nm, {start_o, add_bias_o, valid_o, last_o, busy_o, input_index_o}, 0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int loads, res, idle;
      int rc[8];
      bit rl[8];
      reset_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      d_in    = '{1, 1, 1, 1, 1, 1};
      w       = '{2, 2, 2, 2, 2, 2};
      bias    = 3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset_outputs");
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("reset_ready", ready_o, 1);
      chk("reset_busy", busy_o, 0);

      // Back-to-back: 8 windows, ready held high.
      cur_exp = 15;
      @(posedge clk); #1;
      valid_i = 1'b1;
      loads = 0; res = 0; idle = 0;
      for (int c = 0; c < 200 && res < 8; c++) begin
         @(negedge clk);
         if (loads > 0 && !busy_o) idle++;
         if (valid_o && ready_i) begin
            rc[res] = c;
            rl[res] = last_o;
            res++;
         end
         if (load_o) loads++;
         @(posedge clk); #1;
         if (loads >= 8) valid_i = 1'b0;
      end
      chk("b2b_results", res, 8);
      chk("b2b_idle_cycles", idle, 0);
      for (int i = 1; i < 8; i++) chk("b2b_period", rc[i] - rc[i-1], 9);
      for (int i = 0; i < 8; i++) chk("b2b_last", rl[i], (i == 3 || i == 7));

      // Single window.
      send(15);
      wait_result();
      @(negedge clk);
      chk("single_idle", busy_o, 0);

      // Backpressure in OUT with a pending window.
      ready_i = 1'b0;
      send(15);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (valid_o) break;
      end
      chk("bp_valid_seen", valid_o, 1);
      @(posedge clk); #1;
      valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", valid_o, 1);
         chk("bp_ready", ready_o, 0);
         chk("bp_load", load_o, 0);
         chk("bp_start", start_o, 0);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      @(negedge clk);
      chk("bp_release_load", load_o, 1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk("bp_release_start", start_o, 1);
      wait_result();

      // Reset in cycle 4 after accept aborts the pass and the window count.
      send(15);
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b1;
      @(negedge clk);
      chk_quiet("abort_outputs");
      exp_q.delete();
      exp_win = 0;
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("abort_ready", ready_o, 1);
      chk("abort_busy", busy_o, 0);
      send(15);
      wait_result();

      // ReLU clamps a negative sum.
      bias = -20;
      send(0);
      wait_result();

      // Saturating window, then a small one that needs the overflow flag cleared.
      d_in = '{100, 100, 100, 100, 100, 100};
      w    = '{100, 100, 100, 100, 100, 100};
      bias = 0;
      send(32767);
      wait_result();
      d_in = '{1, 1, 1, 1, 1, 0};
      w    = '{1, 1, 1, 1, 1, 1};
      send(5);
      wait_result();

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
